// File: rtl/fn_des_izq_sec_pkg.sv
`default_nettype none
// ============================================================================
// fn_des_izq_sec_pkg : state encodings and default width for the serial
//                      left shifter and its ALU controller
// Revision 1.0
// ============================================================================
package fn_des_izq_sec_pkg;

  localparam int C_ANCHO_DEF      = 32;
  localparam int C_ANCHO_CANT_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/fn_des_izq_sec.sv
`default_nettype none
// ============================================================================
// fn_des_izq_sec : sequential logical left shifter, one bit per clock,
//                  start/done handshake with the ALU controller
// Revision 1.0
// ============================================================================
module fn_des_izq_sec
  import fn_des_izq_sec_pkg::*;
#(
  parameter int ANCHO      = C_ANCHO_DEF,
  parameter int ANCHO_CANT = C_ANCHO_CANT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ANCHO-1:0]      a,
  input  logic [ANCHO_CANT-1:0] b,
  input  logic                  inicio,
  input  logic                  tomado,
  output logic                  listo,
  output logic                  valido,
  output logic [ANCHO-1:0]      Y
);

  localparam logic [ANCHO_CANT-1:0] C_UNO = {{(ANCHO_CANT-1){1'b0}}, 1'b1};

  estado_t               state_q, state_d;
  logic [ANCHO-1:0]      sr_q, sr_d;
  logic [ANCHO_CANT-1:0] cnt_q, cnt_d;
  logic [ANCHO-1:0]      y_q, y_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (inicio) begin
          sr_d    = a;
          cnt_d   = b;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The counter reaches zero one edge before the result is published,
        // so total latency from accept is b+1 edges.
        if (cnt_q != '0) begin
          sr_d  = {sr_q[ANCHO-2:0], 1'b0};
          cnt_d = cnt_q - C_UNO;
        end else begin
          y_d     = sr_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (tomado) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign listo  = (state_q == ST_IDLE);
  assign valido = (state_q == ST_DONE);
  assign Y      = y_q;

endmodule
`default_nettype wire

// File: tb/tb_fn_des_izq_sec.sv
`default_nettype none
// ============================================================================
// tb_fn_des_izq_sec : vector table, randomized model check and handshake
//                     corner sequences for the serial left shifter
// Revision 1.0
// ============================================================================
module tb_fn_des_izq_sec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_r;
  logic [4:0]  b_r;
  logic        inicio_r;
  logic        tomado_r;
  logic        listo;
  logic        valido;
  logic [31:0] Y;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc   = 0;

  fn_des_izq_sec #(.ANCHO(32), .ANCHO_CANT(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a_r),
    .b      (b_r),
    .inicio (inicio_r),
    .tomado (tomado_r),
    .listo  (listo),
    .valido (valido),
    .Y      (Y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t tabla[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request on a falling edge and accept it on the next rising edge.
  task automatic start(input logic [31:0] av, input logic [4:0] bv);
    @(negedge clk);
    chk("listo_before_start", {31'b0, listo}, 32'd1);
    a_r = av; b_r = bv; inicio_r = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    inicio_r = 1'b0;
    a_r = $urandom; b_r = 5'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valido) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) $display("FAIL timeout: valido never rose, got 0 expected 1");
  endtask

  task automatic ack(input logic [31:0] yexp);
    @(negedge clk);
    tomado_r = 1'b1;
    @(posedge clk); #1;
    chk("ack_listo", {31'b0, listo}, 32'd1);
    chk("ack_valido", {31'b0, valido}, 32'd0);
    chk("ack_Y_kept", Y, yexp);
    @(negedge clk);
    tomado_r = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [31:0] av, input logic [4:0] bv,
                        input logic [31:0] yexp, input int latexp);
    int lat;
    start(av, bv);
    wait_valid(lat);
    chk({nm, "_lat"}, lat, latexp);
    chk({nm, "_Y"}, Y, yexp);
    ack(yexp);
  endtask

  initial begin
    int          lat;
    logic [31:0] ra, yhold;
    logic [4:0]  rb;

    tabla[0] = '{32'h00000001, 5'd4,  32'h00000010, 5};
    tabla[1] = '{32'h80000001, 5'd1,  32'h00000002, 2};
    tabla[2] = '{32'h00000001, 5'd31, 32'h80000000, 32};
    tabla[3] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    tabla[4] = '{32'h00000005, 5'd2,  32'h00000014, 3};

    rst = 1'b1; a_r = '0; b_r = '0; inicio_r = 1'b0; tomado_r = 1'b0;
    #1;
    chk("rst_Y", Y, 32'd0);
    chk("rst_valido", {31'b0, valido}, 32'd0);
    chk("rst_listo", {31'b0, listo}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_op($sformatf("vec%0d", i), tabla[i].a, tabla[i].b, tabla[i].y, tabla[i].lat);

    // Random operands against the plain-arithmetic model a << b.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), ra, rb, ra << rb, int'(rb) + 1);
    end

    // A second request during SHIFT must be ignored.
    start(32'h00000001, 5'd8);
    @(negedge clk);
    inicio_r = 1'b1; a_r = 32'h00000003; b_r = 5'd2;
    @(negedge clk);
    inicio_r = 1'b0; a_r = 32'hFFFFFFFF;
    wait_valid(lat);
    chk("busy_lat", lat, 9);
    chk("busy_Y", Y, 32'h00000100);

    // Hold in DONE, then tomado and inicio together.
    yhold = Y;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (valido !== 1'b1 || Y !== yhold) begin
        chk("hold_valido", {31'b0, valido}, 32'd1);
        chk("hold_Y", Y, yhold);
      end else begin
        n_cmp++;
      end
    end
    @(negedge clk);
    tomado_r = 1'b1; inicio_r = 1'b1; a_r = 32'h00000007; b_r = 5'd1;
    @(posedge clk); #1;
    chk("both_listo", {31'b0, listo}, 32'd1);
    chk("both_valido", {31'b0, valido}, 32'd0);
    @(negedge clk);
    tomado_r = 1'b0; inicio_r = 1'b0;
    @(posedge clk); #1;
    chk("both_no_start", {31'b0, listo}, 32'd1);
    chk("both_Y_kept", Y, 32'h00000100);

    // Asynchronous reset between edges, mid-shift.
    start(32'h12345678, 5'd10);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_Y", Y, 32'd0);
    chk("arst_valido", {31'b0, valido}, 32'd0);
    chk("arst_listo", {31'b0, listo}, 32'd1);
    #1;
    rst = 1'b0;
    run_op("post_rst", 32'h00000005, 5'd2, 32'h00000014, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
